// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, fixed-latency memory between the
// instruction-fetch and load/store requesters. It runs one transaction at a
// time. Data requests have priority, and a starvation guard forces fetch to
// win after STARVE_LIMIT data grants taken while fetch was waiting.
//
// Optional feature macro: MEM_ARB_PERF_EN (wait-cycle performance counters).
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   if_req/if_addr              fetch request and address
//   if_gnt/if_rvalid/if_rdata   fetch grant pulse, data valid pulse, data
//   d_req/d_we/d_addr/d_wdata   data request, store flag, address, store data
//   d_size/d_unsigned           access size (00 B, 01 H, 10 W), unsigned load
//   d_gnt/d_rvalid/d_rdata      data grant pulse, load/store-done pulse, data
//   mem_en/mem_we/mem_addr      memory strobe, write enable, address
//   mem_wdata/mem_size          memory write data, access size
//   mem_unsigned/mem_rdata      unsigned flag, memory read data
//   perf_if_wait/perf_d_wait    fetch/data wait-cycle counters (0 if disabled)
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    output logic              mem_unsigned,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       perf_if_wait,
    output logic [31:0]       perf_d_wait
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned STV_W = 4;

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [STV_W-1:0]  starve_q;
    logic              we_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic starved;
    logic d_win;
    logic if_win;

    // Winner selection; gated by rst_n so no grant leaks out while in reset.
    assign starved = (starve_q == STV_W'(STARVE_LIMIT)) && if_req;
    assign d_win   = rst_n && (state_q == IDLE) && d_req && !starved;
    assign if_win  = rst_n && (state_q == IDLE) && if_req && !d_win;

    // Grant-cycle memory mux and completion pulses.
    always_comb begin
        if_gnt       = if_win;
        d_gnt        = d_win;
        mem_en       = if_win || d_win;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_size     = 2'b00;
        mem_unsigned = 1'b0;
        if (d_win) begin
            mem_we       = d_we;
            mem_addr     = d_addr;
            mem_wdata    = d_wdata;
            mem_size     = d_size;
            mem_unsigned = d_unsigned;
        end else if (if_win) begin
            mem_addr     = if_addr;
            mem_size     = 2'b10;
        end
        if_rvalid = rst_n && (state_q == BUSY_IF) && (cnt_q == '0);
        d_rvalid  = rst_n && (state_q == BUSY_D) && (cnt_q == '0);
        if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
        // Store completions report zero data.
        d_rdata   = d_rvalid ? (we_q ? '0 : mem_rdata) : d_rdata_q;
    end

    // Arbitration FSM, latency counter, starvation counter and rdata hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            starve_q   <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (d_win) begin
                        state_q <= BUSY_D;
                        cnt_q   <= CNT_W'(MEM_LATENCY - 1);
                        we_q    <= d_we;
                        if (if_req) begin
                            if (starve_q != STV_W'(STARVE_LIMIT)) begin
                                starve_q <= starve_q + STV_W'(1);
                            end
                        end else begin
                            starve_q <= '0;
                        end
                    end else if (if_win) begin
                        state_q  <= BUSY_IF;
                        cnt_q    <= CNT_W'(MEM_LATENCY - 1);
                        starve_q <= '0;
                    end else if (!if_req) begin
                        starve_q <= '0;
                    end
                end
                BUSY_IF, BUSY_D: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                    if (if_rvalid) begin
                        if_rdata_q <= mem_rdata;
                    end
                    if (d_rvalid) begin
                        d_rdata_q <= we_q ? '0 : mem_rdata;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_q;
    logic [31:0] perf_d_q;

    // Wait-cycle counters; wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_q <= '0;
            perf_d_q  <= '0;
        end else begin
            if (if_req && !if_gnt) begin
                perf_if_q <= perf_if_q + 32'd1;
            end
            if (d_req && !d_gnt) begin
                perf_d_q <= perf_d_q + 32'd1;
            end
        end
    end

    assign perf_if_wait = perf_if_q;
    assign perf_d_wait  = perf_d_q;
`else
    assign perf_if_wait = 32'd0;
    assign perf_d_wait  = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MEM_LATENCY=2, STARVE_LIMIT=4).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [1:0]  d_size = 2'b00;
    logic        d_unsigned = 1'b0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] mem_rdata = '0;
    logic [31:0] perf_if_wait;
    logic [31:0] perf_d_wait;

    int checks = 0;
    int failures = 0;

`ifdef MEM_ARB_PERF_EN
    localparam logic [31:0] EXP_PERF_IF = 32'd12;
    localparam logic [31:0] EXP_PERF_D  = 32'd8;
`else
    localparam logic [31:0] EXP_PERF_IF = 32'd0;
    localparam logic [31:0] EXP_PERF_D  = 32'd0;
`endif

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_unsigned(d_unsigned), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .mem_rdata(mem_rdata),
        .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start a new cycle: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample point of the current cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_g;
        int idx;

        // Reset state, with a fetch request pending that must not be granted.
        if_req = 1'b1;
        tick();
        sample();
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
        chk("rst_perf", perf_if_wait | perf_d_wait, 32'd0);
        tick();
        if_req = 1'b0;
        rst_n  = 1'b1;

        // Single fetch.
        tick();
        if_req = 1'b1; if_addr = 32'h10;
        sample();
        chk("f_gnt", 32'(if_gnt), 32'd1);
        chk("f_mem_en", 32'(mem_en), 32'd1);
        chk("f_mem_addr", mem_addr, 32'h10);
        chk("f_mem_we", 32'(mem_we), 32'd0);
        chk("f_mem_size", 32'(mem_size), 32'd2);
        chk("f_d_gnt", 32'(d_gnt), 32'd0);
        tick();
        if_req = 1'b0;
        sample();
        chk("f_busy", 32'({if_gnt, mem_en, if_rvalid}), 32'd0);
        tick();
        mem_rdata = 32'hCAFE_0010;
        sample();
        chk("f_rvalid", 32'(if_rvalid), 32'd1);
        chk("f_rdata", if_rdata, 32'hCAFE_0010);
        chk("f_d_rvalid", 32'(d_rvalid), 32'd0);
        tick();
        mem_rdata = 32'h1234_5678;
        sample();
        chk("f_rvalid_end", 32'(if_rvalid), 32'd0);
        chk("f_rdata_hold", if_rdata, 32'hCAFE_0010);

        // Both request in IDLE: data first, fetch three cycles later.
        tick();
        if_req = 1'b1; if_addr = 32'h14;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_size = 2'b01; d_unsigned = 1'b1;
        sample();
        chk("b_d_gnt", 32'({if_gnt, d_gnt}), 32'b01);
        chk("b_mem_addr", mem_addr, 32'h200);
        chk("b_mem_size", 32'(mem_size), 32'd1);
        chk("b_mem_uns", 32'(mem_unsigned), 32'd1);
        tick();
        d_req = 1'b0;
        sample();
        chk("b_c1_gnt", 32'({if_gnt, d_gnt}), 32'd0);
        tick();
        mem_rdata = 32'h0000_8001;
        sample();
        chk("b_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("b_d_rdata", d_rdata, 32'h0000_8001);
        chk("b_c2_gnt", 32'(if_gnt), 32'd0);
        tick();
        sample();
        chk("b_if_gnt", 32'({if_gnt, d_gnt}), 32'b10);
        chk("b_if_addr", mem_addr, 32'h14);
        chk("b_if_size", 32'({mem_size, mem_unsigned}), 32'b100);
        tick();
        if_req = 1'b0;
        tick();
        mem_rdata = 32'h0000_0F0F;
        sample();
        chk("b_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("b_if_rdata", if_rdata, 32'h0000_0F0F);

        // Fresh reset, then both held high: D,D,D,D,F,D,D,D,D,F.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        d_size = 2'b10; d_unsigned = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
        for (int i = 0; i < 30; i++) begin
            tick();
            if_req = 1'b1;
            d_req  = 1'b1;
            sample();
            idx = i / 3;
            if ((i % 3) != 0) exp_g = 2'b00;
            else if ((idx % 5) == 4) exp_g = 2'b10;
            else exp_g = 2'b01;
            chk($sformatf("starve_c%0d", i), 32'({if_gnt, d_gnt}), 32'(exp_g));
            if (i == 12) begin
                chk("perf_if_wait", perf_if_wait, EXP_PERF_IF);
                chk("perf_d_wait", perf_d_wait, EXP_PERF_D);
            end
        end
        tick();
        if_req = 1'b0;
        d_req  = 1'b0;

        // Store byte.
        tick();
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h103; d_wdata = 32'hAB;
        sample();
        chk("s_gnt", 32'({d_gnt, mem_en}), 32'b11);
        chk("s_mem_we", 32'(mem_we), 32'd1);
        chk("s_mem_size", 32'(mem_size), 32'd0);
        chk("s_mem_addr", mem_addr, 32'h103);
        chk("s_mem_wdata", mem_wdata, 32'hAB);
        tick();
        d_req = 1'b0; d_we = 1'b0;
        tick();
        mem_rdata = 32'hFFFF_FFFF;
        sample();
        chk("s_rvalid", 32'(d_rvalid), 32'd1);
        chk("s_rdata", d_rdata, 32'd0);

        // Reset during BUSY_D.
        tick();
        d_req = 1'b1; d_addr = 32'h300; d_size = 2'b10;
        sample();
        chk("r_gnt", 32'(d_gnt), 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        sample();
        chk("r_if_rdata", if_rdata, 32'd0);
        chk("r_outs", 32'({d_gnt, mem_en, d_rvalid, if_rvalid}), 32'd0);
        tick();
        mem_rdata = 32'h0000_0077;
        sample();
        chk("r_no_rvalid", 32'(d_rvalid), 32'd0);
        chk("r_d_gnt_rst", 32'(d_gnt), 32'd0);
        tick();
        rst_n = 1'b1; d_addr = 32'h304;
        sample();
        chk("r_regnt", 32'(d_gnt), 32'd1);
        chk("r_regnt_addr", mem_addr, 32'h304);
        chk("r_rel_rvalid0", 32'(d_rvalid), 32'd0);
        tick();
        d_req = 1'b0;
        sample();
        chk("r_rel_rvalid1", 32'(d_rvalid), 32'd0);
        tick();
        mem_rdata = 32'h0000_0099;
        sample();
        chk("r_rvalid", 32'(d_rvalid), 32'd1);
        chk("r_rdata", d_rdata, 32'h0000_0099);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
